// File: rtl/load_store_unit_if.sv
// Load/store unit bus: CPU request/response handshake plus data-memory port.
// master = CPU + memory side, slave = load_store_unit.
interface load_store_unit_if #(
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W+1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] memory_address;
    logic [31:0]       write_data;
    logic              mem_write;
    logic              mem_read;
    logic [31:0]       read_data;

    modport master (
        output req_valid, req_write, req_size, req_signed,
        output req_addr, req_wdata, resp_ready, read_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  memory_address, write_data, mem_write, mem_read
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed,
        input  req_addr, req_wdata, resp_ready, read_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output memory_address, write_data, mem_write, mem_read
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, byte/half/word, read-modify-write
// for sub-word stores. Ports: clock, reset_n (async, active-low), bus (slave).
module load_store_unit #(
    parameter int ADDR_W = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    load_store_unit_if.slave   bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W+1:0] addr_q;
    logic [1:0]        size_q;
    logic              sgn_q;
    logic              write_q;
    logic              err_q;
    logic [31:0]       rdata_q;
    logic [31:0]       wr_q;

    logic              accept;
    logic              bad;
    logic [1:0]        off;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [31:0]       load_val;
    logic [31:0]       merged;

    assign accept = bus.req_valid && (state == IDLE);
    assign off    = addr_q[1:0];

    assign bad = (bus.req_size == 2'b11)
              || (bus.req_size == 2'b01 && bus.req_addr[0])
              || (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);

    assign lane_b = 8'(bus.read_data >> {off, 3'b000});
    assign lane_h = off[1] ? bus.read_data[31:16]
                           : bus.read_data[15:0];

    always_comb begin
        load_val = bus.read_data;
        unique case (1'b1)
            (size_q == 2'b00):
                load_val = sgn_q ? {{24{lane_b[7]}}, lane_b}
                                 : {24'h0, lane_b};
            (size_q == 2'b01):
                load_val = sgn_q ? {{16{lane_h[15]}}, lane_h}
                                 : {16'h0, lane_h};
            default:
                load_val = bus.read_data;
        endcase
    end

    // Sub-word store: splice the new lane(s) into the word just read.
    always_comb begin
        merged = bus.read_data;
        if (size_q == 2'b00) begin
            unique case (off)
                2'd0: merged[7:0]   = wr_q[7:0];
                2'd1: merged[15:8]  = wr_q[7:0];
                2'd2: merged[23:16] = wr_q[7:0];
                default: merged[31:24] = wr_q[7:0];
            endcase
        end else if (off[1]) begin
            merged[31:16] = wr_q[15:0];
        end else begin
            merged[15:0] = wr_q[15:0];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            addr_q  <= '0;
            size_q  <= 2'b00;
            sgn_q   <= 1'b0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            wr_q    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q  <= bus.req_addr;
                        size_q  <= bus.req_size;
                        sgn_q   <= bus.req_signed;
                        write_q <= bus.req_write;
                        wr_q    <= bus.req_wdata;
                        err_q   <= bad;
                        rdata_q <= '0;
                        if (bad)
                            state <= RESP;
                        else if (bus.req_write && bus.req_size == 2'b10)
                            state <= WRITE;
                        else
                            state <= READ;
                    end
                end
                READ: begin
                    if (write_q) begin
                        wr_q  <= merged;
                        state <= WRITE;
                    end else begin
                        rdata_q <= load_val;
                        state   <= RESP;
                    end
                end
                WRITE: state <= RESP;
                default: begin
                    if (bus.resp_ready)
                        state <= IDLE;
                end
            endcase
        end
    end

    // Memory strobes come straight from the state register, so the
    // asynchronous reset kills an in-flight write before the next edge.
    assign bus.req_ready      = (state == IDLE);
    assign bus.resp_valid     = (state == RESP);
    assign bus.resp_rdata     = rdata_q;
    assign bus.resp_err       = err_q;
    assign bus.mem_read       = (state == READ);
    assign bus.mem_write      = (state == WRITE);
    assign bus.memory_address = addr_q[ADDR_W+1:2];
    assign bus.write_data     = wr_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: scoreboard of expected responses,
// behavioural data memory, directed vectors plus a random burst.
module tb_load_store_unit;
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nrd;
        int          nwr;
        logic [15:0] maddr;
        logic [31:0] wdata;
    } exp_t;

    logic clock;
    logic reset_n;
    logic mem_init_req;

    load_store_unit_if #(.ADDR_W(16)) bus();

    load_store_unit #(.ADDR_W(16)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int          n_tests;
    int          n_fail;
    int          cyc;
    int          t_acc;
    int          n_rd;
    int          n_wr;
    int          lat_seen;
    logic        prev_valid;
    exp_t        sb[$];
    logic [31:0] mem[256];
    logic [31:0] ref_mem[256];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic logic [31:0] seed(input int i);
        return (32'(i) * 32'h0101_0101) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (mem_init_req) begin
            for (int i = 0; i < 256; i++) mem[i] <= seed(i);
        end else if (bus.mem_write) begin
            mem[bus.memory_address[7:0]] <= bus.write_data;
        end
    end

    always @(negedge clock) begin
        if (bus.mem_read)
            bus.read_data <= mem[bus.memory_address[7:0]];
        else
            bus.read_data <= 32'hA5A5_A5A5;
    end

    always @(negedge clock) begin
        if (bus.mem_read) begin
            n_rd++;
            chk("rd_excl", {31'b0, bus.mem_write}, 32'h0);
            if (sb.size() == 0) chk("rd_spurious", sb.size(), 1);
            else chk("rd_addr", bus.memory_address, sb[0].maddr);
        end
        if (bus.mem_write) begin
            n_wr++;
            if (sb.size() == 0) begin
                chk("wr_spurious", sb.size(), 1);
            end else begin
                chk("wr_addr", bus.memory_address, sb[0].maddr);
                chk("wr_data", bus.write_data, sb[0].wdata);
            end
        end
        if (bus.resp_valid && !prev_valid) lat_seen = cyc - t_acc + 1;
        prev_valid = bus.resp_valid;
        if (bus.resp_valid && bus.resp_ready) begin
            if (sb.size() == 0) begin
                chk("resp_spurious", sb.size(), 1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rdata", bus.resp_rdata, e.rdata);
                chk("err", {31'b0, bus.resp_err}, {31'b0, e.err});
                chk("latency", lat_seen, e.lat);
                chk("n_read", n_rd, e.nrd);
                chk("n_write", n_wr, e.nwr);
            end
        end
    end

    function automatic exp_t model(input logic w, input logic [1:0] sz,
                                   input logic sg, input logic [17:0] a,
                                   input logic [31:0] wd);
        exp_t        e;
        logic [31:0] word;
        logic [7:0]  by[4];
        logic [1:0]  off;
        logic [7:0]  b;
        logic [15:0] h;
        word = ref_mem[a[9:2]];
        off  = a[1:0];
        for (int i = 0; i < 4; i++) by[i] = word[8*i +: 8];
        e = '{rdata: 32'h0, err: 1'b0, lat: 0, nrd: 0, nwr: 0,
              maddr: a[17:2], wdata: 32'h0};
        if (sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && off != 0)) begin
            e.err = 1'b1;
            e.lat = 1;
        end else if (!w) begin
            e.lat = 2;
            e.nrd = 1;
            b = by[off];
            h = {by[{off[1], 1'b1}], by[{off[1], 1'b0}]};
            case (sz)
                2'd0: e.rdata = sg ? {{24{b[7]}}, b} : {24'h0, b};
                2'd1: e.rdata = sg ? {{16{h[15]}}, h} : {16'h0, h};
                default: e.rdata = word;
            endcase
        end else if (sz == 2'd2) begin
            e.lat   = 2;
            e.nwr   = 1;
            e.wdata = wd;
        end else begin
            e.lat = 3;
            e.nrd = 1;
            e.nwr = 1;
            if (sz == 2'd0) begin
                by[off] = wd[7:0];
            end else begin
                by[{off[1], 1'b0}] = wd[7:0];
                by[{off[1], 1'b1}] = wd[15:8];
            end
            e.wdata = {by[3], by[2], by[1], by[0]};
        end
        return e;
    endfunction

    task automatic issue(input logic w, input logic [1:0] sz,
                         input logic sg, input logic [17:0] a,
                         input logic [31:0] wd);
        exp_t e;
        int   k;
        e = model(w, sz, sg, a, wd);
        sb.push_back(e);
        if (w && !e.err) ref_mem[a[9:2]] = e.wdata;
        @(negedge clock);
        k = 0;
        while (!bus.req_ready && k < 50) begin
            @(negedge clock);
            k++;
        end
        if (k == 50) chk("ready_wait", {31'b0, bus.req_ready}, 32'h1);
        bus.req_write  = w;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.req_valid  = 1'b1;
        @(posedge clock);
        #1;
        t_acc         = cyc;
        n_rd          = 0;
        n_wr          = 0;
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(negedge clock);
            k++;
        end
        if (sb.size() != 0) chk("drain", sb.size(), 0);
    endtask

    initial begin
        logic [31:0] saved;
        int          k;
        n_tests        = 0;
        n_fail         = 0;
        cyc            = 0;
        t_acc          = 0;
        n_rd           = 0;
        n_wr           = 0;
        lat_seen       = 0;
        prev_valid     = 1'b0;
        mem_init_req   = 1'b1;
        reset_n        = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = seed(i);
        repeat (3) @(negedge clock);
        mem_init_req = 1'b0;
        chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
        chk("rst_resp_err", {31'b0, bus.resp_err}, 32'h0);
        chk("rst_rdata", bus.resp_rdata, 32'h0);
        chk("rst_mem_read", {31'b0, bus.mem_read}, 32'h0);
        chk("rst_mem_write", {31'b0, bus.mem_write}, 32'h0);
        chk("rst_maddr", bus.memory_address, 32'h0);
        chk("rst_wdata", bus.write_data, 32'h0);
        reset_n = 1'b1;
        #1;
        chk("req_ready_after_rst", {31'b0, bus.req_ready}, 32'h1);

        issue(1'b1, 2'd2, 1'b0, 18'h0010, 32'hDEAD_BEEF);
        issue(1'b1, 2'd0, 1'b0, 18'h0012, 32'h0000_0055);
        issue(1'b0, 2'd2, 1'b0, 18'h0010, 32'h0);

        issue(1'b1, 2'd2, 1'b0, 18'h0020, 32'h80FF_7F01);
        for (int i = 0; i < 4; i++)
            issue(1'b0, 2'd0, 1'b1, 18'h0020 + 18'(i), 32'h0);
        issue(1'b0, 2'd1, 1'b0, 18'h0022, 32'h0);
        issue(1'b0, 2'd1, 1'b1, 18'h0022, 32'h0);
        issue(1'b0, 2'd1, 1'b1, 18'h0020, 32'h0);
        issue(1'b0, 2'd0, 1'b0, 18'h0023, 32'h0);
        issue(1'b0, 2'd2, 1'b1, 18'h0020, 32'h0);

        issue(1'b0, 2'd1, 1'b0, 18'h0013, 32'h0);
        issue(1'b0, 2'd3, 1'b0, 18'h0020, 32'h0);
        issue(1'b1, 2'd2, 1'b0, 18'h0021, 32'h1111_1111);
        issue(1'b1, 2'd1, 1'b0, 18'h0022, 32'hCAFE_1234);
        issue(1'b1, 2'd1, 1'b0, 18'h0030, 32'h0000_ABCD);
        issue(1'b0, 2'd2, 1'b0, 18'h0020, 32'h0);
        issue(1'b0, 2'd2, 1'b0, 18'h0030, 32'h0);
        drain();

        bus.resp_ready = 1'b0;
        issue(1'b0, 2'd1, 1'b1, 18'h0022, 32'h0);
        k = 0;
        while (!bus.resp_valid && k < 20) begin
            @(negedge clock);
            k++;
        end
        if (!bus.resp_valid) chk("stall_valid_wait", 32'h0, 32'h1);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {31'b0, bus.resp_valid}, 32'h1);
            chk("stall_rdata", bus.resp_rdata, sb[0].rdata);
            chk("stall_ready", {31'b0, bus.req_ready}, 32'h0);
            @(negedge clock);
        end
        @(posedge clock);
        #1;
        bus.resp_ready = 1'b1;
        @(posedge clock);
        #1;
        chk("stall_idle", {31'b0, bus.req_ready}, 32'h1);
        drain();

        saved = ref_mem[8'h10];
        issue(1'b1, 2'd0, 1'b0, 18'h0041, 32'h0000_00AB);
        k = 0;
        while (!bus.mem_write && k < 20) begin
            @(negedge clock);
            k++;
        end
        if (!bus.mem_write) chk("rst_write_wait", 32'h0, 32'h1);
        reset_n = 1'b0;
        #1;
        chk("rst_wr_mem_write", {31'b0, bus.mem_write}, 32'h0);
        chk("rst_wr_idle", {31'b0, bus.req_ready}, 32'h1);
        chk("rst_wr_valid", {31'b0, bus.resp_valid}, 32'h0);
        chk("rst_wr_wdata", bus.write_data, 32'h0);
        sb.delete();
        ref_mem[8'h10] = saved;
        @(posedge clock);
        #1;
        chk("rst_wr_mem_kept", mem[8'h10], saved);
        @(negedge clock);
        reset_n = 1'b1;
        issue(1'b0, 2'd2, 1'b0, 18'h0040, 32'h0);
        drain();

        for (int i = 0; i < 24; i++) begin
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 18'($urandom_range(0, 1023)),
                  $urandom);
        end
        for (int i = 0; i < 8; i++)
            issue(1'b0, 2'd2, 1'b0, 18'(4 * $urandom_range(0, 255)), 32'h0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
